// File: rtl/exc_irq_controller.sv
// rtl/exc_irq_controller.sv - fixed-priority exception/interrupt arbiter with take/eret handshake
// Optional EXC_IRQ_SYNC_EN adds a 2-flop synchronizer ahead of irq_q.
module exc_irq_controller #(
   parameter int NUM_EXC = 16,
   parameter int NUM_IRQ = 4,
   localparam int CAUSE_W = 1 + (($clog2(NUM_EXC) > $clog2(NUM_IRQ)) ? $clog2(NUM_EXC) : $clog2(NUM_IRQ))
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_EXC-1:0] exc_trigger,
   input  logic [NUM_EXC-1:0] exc_mask,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic [NUM_IRQ-1:0] irq_mask,
   input  logic               int_enable,
   input  logic               take,
   input  logic               eret,
   output logic               trap_req,
   output logic               exc_pending,
   output logic               int_pending,
   output logic [CAUSE_W-1:0] cause,
   output logic               in_handler,
   output logic [NUM_IRQ-1:0] irq_ack
);

   localparam int IDX_W = CAUSE_W - 1;

   typedef enum logic {
      IDLE    = 1'b0,
      HANDLER = 1'b1
   } state_e;

   state_e             state_q;
   logic [NUM_EXC-1:0] pend_exc_q;
   logic [NUM_EXC-1:0] pend_exc_d;
   logic [NUM_EXC-1:0] exc_clr;
   logic [NUM_IRQ-1:0] irq_src;
   logic [NUM_IRQ-1:0] irq_q;
   logic [NUM_IRQ-1:0] eligible;
   logic [NUM_IRQ-1:0] irq_ack_q;
   logic [CAUSE_W-1:0] cause_q;
   logic [IDX_W-1:0]   exc_idx;
   logic [IDX_W-1:0]   irq_idx;

`ifdef EXC_IRQ_SYNC_EN
   logic [NUM_IRQ-1:0] sync1_q;
   logic [NUM_IRQ-1:0] sync2_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= irq_in;
         sync2_q <= sync1_q;
      end
   end

   assign irq_src = sync2_q;
`else
   assign irq_src = irq_in;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         irq_q <= '0;
      end else begin
         irq_q <= irq_src;
      end
   end

   assign eligible    = irq_q & irq_mask;
   assign exc_pending = |pend_exc_q;
   assign int_pending = int_enable & (|eligible) & (state_q == IDLE);
   assign trap_req    = exc_pending | int_pending;

   // Descending scan so the lowest set index is the last one assigned.
   always_comb begin
      exc_idx = '0;
      for (int i = NUM_EXC - 1; i >= 0; i--) begin
         if (pend_exc_q[i]) exc_idx = IDX_W'(i);
      end
      irq_idx = '0;
      for (int j = NUM_IRQ - 1; j >= 0; j--) begin
         if (eligible[j]) irq_idx = IDX_W'(j);
      end
   end

   // A fresh trigger is ORed in after the clear, so a same-cycle set survives.
   always_comb begin
      exc_clr    = (take && exc_pending) ? (NUM_EXC'(1) << exc_idx) : '0;
      pend_exc_d = (pend_exc_q & ~exc_clr) | (exc_trigger & exc_mask);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cause_q    <= '0;
         irq_ack_q  <= '0;
         pend_exc_q <= '0;
      end else begin
         pend_exc_q <= pend_exc_d;
         irq_ack_q  <= '0;
         if (take && trap_req) begin
            state_q <= HANDLER;
            if (exc_pending) begin
               cause_q <= {1'b0, exc_idx};
            end else begin
               cause_q   <= {1'b1, irq_idx};
               irq_ack_q <= NUM_IRQ'(1) << irq_idx;
            end
         end else if (eret && state_q == HANDLER) begin
            state_q <= IDLE;
         end
      end
   end

   assign cause      = cause_q;
   assign in_handler = (state_q == HANDLER);
   assign irq_ack    = irq_ack_q;

endmodule

// File: tb/tb_exc_irq_controller.sv
// tb/tb_exc_irq_controller.sv - directed and randomized checks of exc_irq_controller
// Honors EXC_IRQ_SYNC_EN for the expected irq latency.
module tb_exc_irq_controller;

   localparam int NE = 16;
   localparam int NI = 4;
   localparam int CW = 5;
`ifdef EXC_IRQ_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [NE-1:0] exc_trigger;
   logic [NE-1:0] exc_mask;
   logic [NI-1:0] irq_in;
   logic [NI-1:0] irq_mask;
   logic          int_enable;
   logic          take;
   logic          eret;
   logic          trap_req;
   logic          exc_pending;
   logic          int_pending;
   logic [CW-1:0] cause;
   logic          in_handler;
   logic [NI-1:0] irq_ack;

   int checks = 0;
   int errors = 0;

   logic [NE-1:0] m_pend;
   logic [NI-1:0] m_pipe [LAT];
   logic          m_inh;
   logic [CW-1:0] m_cause;
   logic [NI-1:0] m_ack;

   exc_irq_controller #(.NUM_EXC(NE), .NUM_IRQ(NI)) dut (
      .clk(clk), .reset(reset), .exc_trigger(exc_trigger), .exc_mask(exc_mask),
      .irq_in(irq_in), .irq_mask(irq_mask), .int_enable(int_enable), .take(take),
      .eret(eret), .trap_req(trap_req), .exc_pending(exc_pending), .int_pending(int_pending),
      .cause(cause), .in_handler(in_handler), .irq_ack(irq_ack)
   );

   always #5 clk = ~clk;

   // Index of the lowest set bit: isolate it with v & -v, then take its log2.
   function automatic int lowest(input logic [31:0] v);
      logic [31:0] iso;
      iso = v & (~v + 32'd1);
      return $clog2(iso);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      logic [NI-1:0] elig;
      logic          ip, ep;
      elig = m_pipe[LAT-1] & irq_mask;
      ip   = int_enable && (elig != 0) && !m_inh;
      ep   = (m_pend != 0);
      chk("exc_pending", exc_pending, ep);
      chk("int_pending", int_pending, ip);
      chk("trap_req", trap_req, ep | ip);
      chk("cause", cause, m_cause);
      chk("in_handler", in_handler, m_inh);
      chk("irq_ack", irq_ack, m_ack);
   endtask

   task automatic model_update();
      logic [NI-1:0] elig;
      logic          ip, ep;
      int            idx;
      elig = m_pipe[LAT-1] & irq_mask;
      ip   = int_enable && (elig != 0) && !m_inh;
      ep   = (m_pend != 0);
      if (reset) begin
         m_pend  = '0;
         m_inh   = 1'b0;
         m_cause = '0;
         m_ack   = '0;
         for (int k = 0; k < LAT; k++) m_pipe[k] = '0;
      end else begin
         m_ack = '0;
         if (take && (ep || ip)) begin
            if (ep) begin
               idx     = lowest(32'(m_pend));
               m_cause = CW'(idx);
               m_pend[idx] = 1'b0;
            end else begin
               idx     = lowest(32'(elig));
               m_cause = CW'(16 + idx);
               m_ack   = NI'(1 << idx);
            end
            m_inh = 1'b1;
         end else if (eret) begin
            m_inh = 1'b0;
         end
         m_pend = m_pend | (exc_trigger & exc_mask);
         for (int k = LAT - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
         m_pipe[0] = irq_in;
      end
   endtask

   task automatic tick(input bit do_check = 1'b1);
      #1;
      if (do_check) check_model();
      model_update();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int lat_seen;
      m_pend = '0; m_inh = 1'b0; m_cause = '0; m_ack = '0;
      for (int k = 0; k < LAT; k++) m_pipe[k] = '0;

      @(negedge clk);
      reset = 1'b1; exc_trigger = '1; exc_mask = '1; irq_in = 4'hF; irq_mask = 4'hF;
      int_enable = 1'b1; take = 1'b0; eret = 1'b0;
      tick(1'b0);
      tick();
      reset = 1'b0; exc_trigger = '0; irq_in = '0;
      tick();
      #1;
      chk("rst_trap_req", trap_req, 0);
      chk("rst_exc_pending", exc_pending, 0);
      chk("rst_cause", cause, 0);
      chk("rst_in_handler", in_handler, 0);
      chk("rst_irq_ack", irq_ack, 0);

      exc_trigger = NE'((1 << 3) | (1 << 7));
      tick();
      exc_trigger = '0; take = 1'b1;
      tick();
      take = 1'b0;
      #1;
      chk("prio_cause3", cause, 5'h03);
      chk("prio_bit7_left", exc_pending, 1);
      eret = 1'b1;
      tick();
      eret = 1'b0; take = 1'b1;
      tick();
      take = 1'b0;
      #1;
      chk("prio_cause7", cause, 5'h07);
      chk("prio_drained", exc_pending, 0);
      eret = 1'b1;
      tick();
      eret = 1'b0;

      irq_mask = 4'b0110; irq_in = 4'b1100;
      for (int k = 0; k < LAT; k++) tick();
      #1;
      chk("irq_int_pending", int_pending, 1);
      take = 1'b1;
      tick();
      take = 1'b0;
      #1;
      chk("irq_cause", cause, 5'h12);
      chk("irq_ack_pulse", irq_ack, 4'b0100);
      chk("irq_in_handler", in_handler, 1);
      chk("irq_no_int_in_handler", int_pending, 0);
      irq_in = '0;
      tick();
      #1;
      chk("irq_ack_one_cycle", irq_ack, 0);
      eret = 1'b1;
      for (int k = 0; k < LAT; k++) tick();
      eret = 1'b0;

      irq_in = 4'b0100; exc_trigger = NE'(1 << 5);
      tick();
      exc_trigger = '0;
      for (int k = 0; k < LAT; k++) tick();
      take = 1'b1;
      tick();
      take = 1'b0;
      #1;
      chk("nest_exc_beats_irq", cause, 5'h05);
      exc_trigger = NE'(1 << 1);
      tick();
      exc_trigger = '0; take = 1'b1;
      tick();
      take = 1'b0;
      #1;
      chk("nest_cause1", cause, 5'h01);
      chk("nest_in_handler", in_handler, 1);
      irq_in = '0; eret = 1'b1;
      for (int k = 0; k < LAT + 1; k++) tick();
      eret = 1'b0;

      exc_trigger = NE'(1 << 9);
      tick();
      exc_trigger = '0; take = 1'b1;
      tick();
      eret = 1'b1;
      tick();
      take = 1'b0; eret = 1'b0;
      #1;
      chk("coll_take_eret_idle", in_handler, 0);
      exc_trigger = NE'(1 << 4);
      tick();
      take = 1'b1;
      tick();
      take = 1'b0; exc_trigger = '0;
      #1;
      chk("coll_set_wins", exc_pending, 1);
      chk("coll_cause4", cause, 5'h04);
      eret = 1'b1;
      tick();
      eret = 1'b0; take = 1'b1;
      tick();
      take = 1'b0; eret = 1'b1;
      tick();
      eret = 1'b0;

      irq_mask = 4'b0001; int_enable = 1'b1; irq_in = 4'b0001;
      lat_seen = 0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         #1;
         if (int_pending && lat_seen == 0) lat_seen = k;
      end
      chk("irq_latency", lat_seen, LAT);
      irq_in = '0;
      for (int k = 0; k < LAT; k++) tick();

      for (int n = 0; n < 3000; n++) begin
         reset       = ($urandom_range(0, 63) == 0);
         exc_trigger = NE'($urandom & $urandom & $urandom);
         exc_mask    = ($urandom_range(0, 3) == 0) ? NE'($urandom) : '1;
         if ($urandom_range(0, 3) == 0) irq_in = NI'($urandom);
         irq_mask    = NI'($urandom);
         int_enable  = ($urandom_range(0, 3) != 0);
         take        = ($urandom_range(0, 2) == 0);
         eret        = ($urandom_range(0, 3) == 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/exc_irq_controller.md
# exc_irq_controller

Parametrised exception and interrupt controller for the cpu32e2 core: latches up to NUM_EXC synchronous exception triggers and NUM_IRQ level interrupt lines, and arbitrates them by fixed priority. It hands one trap at a time to the control unit through a take/eret handshake, tracks handler occupancy and produces the vectored cause code. It sits between the execute stage and the external interrupt fabric.

## Interface
Parameters:
- NUM_EXC, 16: number of exception sources, 2..32.
- NUM_IRQ, 4: number of interrupt lines, 1..32.
- CAUSE_W, 1+max($clog2(NUM_EXC),$clog2(NUM_IRQ)): cause width, derived, not overridden.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- exc_trigger  in  NUM_EXC  one-cycle exception event pulses.
- exc_mask  in  NUM_EXC  1 = exception source enabled.
- irq_in  in  NUM_IRQ  level-sensitive interrupt requests.
- irq_mask  in  NUM_IRQ  1 = interrupt line enabled.
- int_enable  in  1  global interrupt enable.
- take  in  1  core at instruction boundary, entering trap if trap_req.
- eret  in  1  return from handler.
- trap_req  out  1  exc_pending | int_pending.
- exc_pending  out  1  any latched exception.
- int_pending  out  1  interrupt eligible for taking.
- cause  out  CAUSE_W  code of last taken trap.
- in_handler  out  1  handler active.
- irq_ack  out  NUM_IRQ  one-hot, one-cycle acknowledge of taken line.

## Operation
- pend_exc[i] is set on exc_trigger[i] & exc_mask[i]. It is sticky until that bit is taken. Clearing is per bit; other pending bits survive.
- Masking exc_mask[i] after latch does not clear pend_exc[i].
- irq_in passes through one register stage, irq_q. Eligible lines are irq_q & irq_mask.
- int_pending = int_enable & |eligible & (state==IDLE).
- exc_pending = |pend_exc, in any state.
- Priority: lowest index wins within each class. Exceptions beat interrupts.
- Cause encoding: exception i gives {1'b0, i}; interrupt j gives {1'b1, j}. Both are zero-extended to CAUSE_W-1 index bits.
- FSM states: IDLE and HANDLER.
- take & trap_req:
  - Loads cause.
  - For an exception, clears the winning pend_exc bit.
  - For an interrupt, pulses irq_ack[j].
  - state goes to HANDLER.
- take & !trap_req: ignored.
- Exception taken while in HANDLER (nested fault): cause is overwritten and state stays HANDLER. Interrupts are never taken in HANDLER.
- eret in HANDLER: goes to IDLE. eret in IDLE: ignored.
- take and eret in the same cycle: if trap_req, take wins and state ends in HANDLER; else eret applies.
- exc_trigger[i] in the same cycle that take clears bit i: set wins and the bit stays pending.
- Interrupts are level-based. A line still high after the handler returns re-requests. irq_ack is the device's cue to drop the line.

## Timing
- Reset values: cause 0, in_handler 0, irq_ack 0, trap_req 0, exc_pending 0, int_pending 0, pend_exc 0, irq_q 0, state IDLE.
- reset asserted mid-handler returns everything to reset values on the next clock edge.
- exc_trigger to exc_pending: 1 cycle. This is the registered pend_exc; trap_req and exc_pending are combinational from state registers.
- irq_in to int_pending: 1 cycle, or 3 with the synchronizer.
- int_enable and irq_mask act combinationally on int_pending in the same cycle.
- take at edge N:
  - cause, in_handler and irq_ack are valid after edge N.
  - irq_ack is high for exactly one cycle.
  - The cleared pend_exc bit is visible after edge N.
- eret at edge N: in_handler is low after edge N. A pending interrupt can be taken from the following cycle.

## Configuration
- EXC_IRQ_SYNC_EN defined: each irq_in bit passes through a 2-flop synchronizer before irq_q. Total irq_in to int_pending latency is 3 cycles. Synchronizer flops reset to 0.
- Not defined: only the single irq_q stage. Latency is 1 cycle; irq_in must already be synchronous to clk.

## Test plan
- Reset state: hold reset 2 cycles with irq_in=4'hF and exc_trigger=all ones -> all outputs 0 one cycle after reset release, with no latch of exc_trigger from reset cycles.
- Exception priority and per-bit clear: exc_trigger bits 3 and 7 together, mask all ones, take -> cause=5'h03 and bit 7 still pending. Then eret and take -> cause=5'h07, exc_pending=0.
- Interrupt path: int_enable=1, irq_mask=4'b0110, irq_in=4'b1100 -> int_pending after 1 cycle. take -> cause=5'h12, irq_ack=4'b0100 for one cycle, in_handler=1, int_pending=0.
- Exception beats interrupt and nests: irq2 and exc5 pending, take -> cause=5'h05. Then exc1 triggers in HANDLER and take -> cause=5'h01, in_handler stays 1.
- Collisions: take and eret together with nothing pending -> in_handler=0. exc_trigger[4] in the same cycle take clears bit 4 -> exc_pending stays 1.
- EXC_IRQ_SYNC_EN build: irq_in[0] rises -> int_pending exactly 3 cycles later. Without the macro -> 1 cycle.
